// File: rtl/alarm_set_ctrl_if.sv
// Bundle between the alarm controller and its neighbours: debounced button
// ticks and the running time in, the renderer-facing alarm digits out.
interface alarm_set_ctrl_if;
  logic       mode_tick;
  logic       inc_tick;
  logic       dec_tick;
  logic       alarm_en;
  logic [3:0] insecMSB;
  logic [3:0] insecLSB;
  logic [3:0] inminMSB;
  logic [3:0] inminLSB;
  logic [3:0] inhourMSB;
  logic [3:0] inhourLSB;
  logic [1:0] selection;
  logic [3:0] alarmsecMSB;
  logic [3:0] alarmsecLSB;
  logic [3:0] alarmminMSB;
  logic [3:0] alarmminLSB;
  logic [3:0] alarmhourMSB;
  logic [3:0] alarmhourLSB;
  logic       alarm_ring;

  modport master (
    output mode_tick, inc_tick, dec_tick, alarm_en,
    output insecMSB, insecLSB, inminMSB, inminLSB, inhourMSB, inhourLSB,
    input  selection,
    input  alarmsecMSB, alarmsecLSB, alarmminMSB, alarmminLSB,
    input  alarmhourMSB, alarmhourLSB,
    input  alarm_ring
  );

  modport slave (
    input  mode_tick, inc_tick, dec_tick, alarm_en,
    input  insecMSB, insecLSB, inminMSB, inminLSB, inhourMSB, inhourLSB,
    output selection,
    output alarmsecMSB, alarmsecLSB, alarmminMSB, alarmminLSB,
    output alarmhourMSB, alarmhourLSB,
    output alarm_ring
  );
endinterface

// File: rtl/alarm_set_ctrl.sv
// Alarm-time editor and ring latch: owns the six BCD alarm digits, the edit
// field selection with idle auto-return, and the registered time/alarm match.
module alarm_set_ctrl #(
  parameter int IDLE_TIMEOUT = 500_000_000,
  parameter int TO_W         = 29
) (
  input logic             clk,
  input logic             reset,
  alarm_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    SEL0 = 2'd0,
    SEL1 = 2'd1,
    SEL2 = 2'd2,
    SEL3 = 2'd3
  } sel_t;

  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(IDLE_TIMEOUT - 1);

  sel_t            state_reg, state_next;
  logic [TO_W-1:0] count_reg, count_next;
  logic            edit_en;
  logic            match_now;
  logic            match_reg, match_q;
  logic            ring_reg, ring_next;
  logic            clear_ring;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEL0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // mode_tick wins over both the idle timeout and any coincident edit.
  always_comb begin
    state_next = state_reg;
    count_next = '0;
    if (bus.mode_tick) begin
      case (state_reg)
        SEL0: state_next = SEL1;
        SEL1: state_next = SEL2;
        SEL2: state_next = SEL3;
        SEL3: state_next = SEL0;
      endcase
    end else if (state_reg != SEL0) begin
      if (bus.inc_tick || bus.dec_tick) begin
        count_next = '0;
      end else if (count_reg == TIMEOUT_LAST) begin
        state_next = SEL0;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  // inc and dec together cancel out.
  assign edit_en = (state_reg != SEL0) && !bus.mode_tick && (bus.inc_tick ^ bus.dec_tick);

  // Pair 0 = seconds, 1 = minutes, 2 = hours; each wraps at its own top value.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pair
      localparam logic [1:0] PAIR_SEL = 2'(gi + 1);
      localparam logic [3:0] TOP_MSB  = (gi == 2) ? 4'd2 : 4'd5;
      localparam logic [3:0] TOP_LSB  = (gi == 2) ? 4'd3 : 4'd9;

      logic [3:0] msb_reg, lsb_reg;
      logic [3:0] msb_next, lsb_next;

      always_comb begin
        msb_next = msb_reg;
        lsb_next = lsb_reg;
        if (edit_en && (state_reg == PAIR_SEL)) begin
          if (bus.inc_tick) begin
            if ((msb_reg == TOP_MSB) && (lsb_reg == TOP_LSB)) begin
              msb_next = 4'd0;
              lsb_next = 4'd0;
            end else if (lsb_reg == 4'd9) begin
              msb_next = msb_reg + 4'd1;
              lsb_next = 4'd0;
            end else begin
              lsb_next = lsb_reg + 4'd1;
            end
          end else begin
            if ((msb_reg == 4'd0) && (lsb_reg == 4'd0)) begin
              msb_next = TOP_MSB;
              lsb_next = TOP_LSB;
            end else if (lsb_reg == 4'd0) begin
              msb_next = msb_reg - 4'd1;
              lsb_next = 4'd9;
            end else begin
              lsb_next = lsb_reg - 4'd1;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          msb_reg <= 4'd0;
          lsb_reg <= 4'd0;
        end else begin
          msb_reg <= msb_next;
          lsb_reg <= lsb_next;
        end
      end
    end
  endgenerate

  assign match_now = bus.alarm_en && (state_reg == SEL0) &&
    ({bus.inhourMSB, bus.inhourLSB, bus.inminMSB, bus.inminLSB, bus.insecMSB, bus.insecLSB} ==
     {g_pair[2].msb_reg, g_pair[2].lsb_reg, g_pair[1].msb_reg, g_pair[1].lsb_reg,
      g_pair[0].msb_reg, g_pair[0].lsb_reg});

  // Only a fresh rising edge of the registered match may set the ring;
  // any button activity or disarming clears it, and clearing wins.
  assign clear_ring = bus.mode_tick || bus.inc_tick || bus.dec_tick || !bus.alarm_en;

  always_comb begin
    ring_next = ring_reg;
    if (clear_ring) begin
      ring_next = 1'b0;
    end else if (match_reg && !match_q) begin
      ring_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match_reg <= 1'b0;
      match_q   <= 1'b0;
      ring_reg  <= 1'b0;
    end else begin
      match_reg <= match_now;
      match_q   <= match_reg;
      ring_reg  <= ring_next;
    end
  end

  assign bus.selection    = state_reg;
  assign bus.alarmsecMSB  = g_pair[0].msb_reg;
  assign bus.alarmsecLSB  = g_pair[0].lsb_reg;
  assign bus.alarmminMSB  = g_pair[1].msb_reg;
  assign bus.alarmminLSB  = g_pair[1].lsb_reg;
  assign bus.alarmhourMSB = g_pair[2].msb_reg;
  assign bus.alarmhourLSB = g_pair[2].lsb_reg;
  assign bus.alarm_ring   = ring_reg;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: a vector table with repeat counts plus
// hand-written idle-timeout and mid-edit reset sequences.
module tb_alarm_set_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  alarm_set_ctrl_if bus ();

  alarm_set_ctrl #(
    .IDLE_TIMEOUT(10),
    .TO_W        (29)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          rep;
    logic        mode;
    logic        inc;
    logic        dec;
    logic        en;
    logic [23:0] tm;
    logic [1:0]  sel;
    logic [23:0] alarm;
    logic        ring;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(int rep, logic m, logic i, logic d, logic e,
                             logic [23:0] tm, logic [1:0] s, logic [23:0] a, logic r);
    vec_t x;
    x.rep = rep; x.mode = m; x.inc = i; x.dec = d; x.en = e;
    x.tm = tm; x.sel = s; x.alarm = a; x.ring = r;
    return x;
  endfunction

  function automatic logic [23:0] alarm_now();
    return {bus.alarmhourMSB, bus.alarmhourLSB, bus.alarmminMSB, bus.alarmminLSB,
            bus.alarmsecMSB, bus.alarmsecLSB};
  endfunction

  task automatic drive(logic m, logic i, logic d, logic e, logic [23:0] tm);
    bus.mode_tick = m;
    bus.inc_tick  = i;
    bus.dec_tick  = d;
    bus.alarm_en  = e;
    {bus.inhourMSB, bus.inhourLSB, bus.inminMSB, bus.inminLSB,
     bus.insecMSB, bus.insecLSB} = tm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int idx, logic [23:0] got, logic [23:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s #%0d: got %h required %h", nm, idx, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic chk_all(string tag, int idx, logic [1:0] s, logic [23:0] a, logic r);
    chk({tag, "_sel"}, idx, 24'(bus.selection), 24'(s));
    chk({tag, "_alarm"}, idx, alarm_now(), a);
    chk({tag, "_ring"}, idx, 24'(bus.alarm_ring), 24'(r));
    $display("%s %0d: sel=%0d alarm=%h ring=%0b", tag, idx, bus.selection, alarm_now(),
             bus.alarm_ring);
  endtask

  initial begin
    // Selection walk and seconds wrap with BCD carry/borrow.
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd1, 24'h000000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd2, 24'h000000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd3, 24'h000000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd0, 24'h000000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd1, 24'h000000, 0));
    vq.push_back(v(9,  0, 1, 0, 0, 24'h0, 2'd1, 24'h000009, 0));
    vq.push_back(v(1,  0, 1, 0, 0, 24'h0, 2'd1, 24'h000010, 0));
    vq.push_back(v(49, 0, 1, 0, 0, 24'h0, 2'd1, 24'h000059, 0));
    vq.push_back(v(1,  0, 1, 0, 0, 24'h0, 2'd1, 24'h000000, 0));
    vq.push_back(v(1,  0, 0, 1, 0, 24'h0, 2'd1, 24'h000059, 0));
    vq.push_back(v(1,  0, 1, 0, 0, 24'h0, 2'd1, 24'h000000, 0));
    // Hours wrap both ways.
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd2, 24'h000000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd3, 24'h000000, 0));
    vq.push_back(v(1,  0, 0, 1, 0, 24'h0, 2'd3, 24'h230000, 0));
    vq.push_back(v(1,  0, 1, 0, 0, 24'h0, 2'd3, 24'h000000, 0));
    vq.push_back(v(1,  0, 0, 1, 0, 24'h0, 2'd3, 24'h230000, 0));
    vq.push_back(v(3,  0, 0, 1, 0, 24'h0, 2'd3, 24'h200000, 0));
    vq.push_back(v(1,  0, 0, 1, 0, 24'h0, 2'd3, 24'h190000, 0));
    vq.push_back(v(1,  0, 1, 0, 0, 24'h0, 2'd3, 24'h200000, 0));
    // Edits ignored in SEL0; simultaneous-event priorities in SEL2.
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd0, 24'h200000, 0));
    vq.push_back(v(1,  0, 1, 0, 0, 24'h0, 2'd0, 24'h200000, 0));
    vq.push_back(v(1,  0, 0, 1, 0, 24'h0, 2'd0, 24'h200000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd1, 24'h200000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd2, 24'h200000, 0));
    vq.push_back(v(30, 0, 1, 0, 0, 24'h0, 2'd2, 24'h203000, 0));
    vq.push_back(v(1,  0, 1, 1, 0, 24'h0, 2'd2, 24'h203000, 0));
    vq.push_back(v(1,  0, 0, 1, 0, 24'h0, 2'd2, 24'h202900, 0));
    vq.push_back(v(1,  0, 1, 0, 0, 24'h0, 2'd2, 24'h203000, 0));
    vq.push_back(v(1,  1, 1, 0, 0, 24'h0, 2'd3, 24'h203000, 0));
    vq.push_back(v(1,  1, 0, 1, 0, 24'h0, 2'd0, 24'h203000, 0));
    // Program alarm 07:15:00.
    vq.push_back(v(3,  1, 0, 0, 0, 24'h0, 2'd3, 24'h203000, 0));
    vq.push_back(v(11, 0, 1, 0, 0, 24'h0, 2'd3, 24'h073000, 0));
    vq.push_back(v(1,  1, 0, 0, 0, 24'h0, 2'd0, 24'h073000, 0));
    vq.push_back(v(2,  1, 0, 0, 0, 24'h0, 2'd2, 24'h073000, 0));
    vq.push_back(v(15, 0, 0, 1, 0, 24'h0, 2'd2, 24'h071500, 0));
    vq.push_back(v(2,  1, 0, 0, 0, 24'h0, 2'd0, 24'h071500, 0));
    // Match, ring latency, clears, and re-arm on a fresh match edge.
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 1));
    vq.push_back(v(3,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 1));
    vq.push_back(v(1,  0, 1, 0, 1, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(4,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071501, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 1));
    vq.push_back(v(1,  0, 0, 0, 0, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 1));
    vq.push_back(v(1,  1, 0, 0, 1, 24'h071500, 2'd1, 24'h071500, 0));
    vq.push_back(v(3,  0, 0, 0, 1, 24'h071500, 2'd1, 24'h071500, 0));
    vq.push_back(v(1,  1, 0, 0, 1, 24'h071500, 2'd2, 24'h071500, 0));
    vq.push_back(v(5,  0, 0, 0, 1, 24'h071500, 2'd2, 24'h071500, 0));
    vq.push_back(v(2,  1, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(1,  0, 0, 0, 1, 24'h071500, 2'd0, 24'h071500, 1));
    vq.push_back(v(1,  1, 0, 0, 1, 24'h071500, 2'd1, 24'h071500, 0));
    vq.push_back(v(3,  1, 0, 0, 0, 24'h071500, 2'd0, 24'h071500, 0));
    vq.push_back(v(4,  0, 0, 0, 0, 24'h071500, 2'd0, 24'h071500, 0));

    drive(0, 0, 0, 0, 24'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_all("reset", 0, 2'd0, 24'h000000, 1'b0);

    foreach (vq[k]) begin
      for (int r = 0; r < vq[k].rep; r++) begin
        drive(vq[k].mode, vq[k].inc, vq[k].dec, vq[k].en, vq[k].tm);
        step();
      end
      chk_all("vec", k, vq[k].sel, vq[k].alarm, vq[k].ring);
    end

    // Idle timeout: selection returns to 0 exactly 10 cycles after entering SEL1.
    drive(1, 0, 0, 0, 24'h0);
    step();
    chk_all("to_enter", 0, 2'd1, 24'h071500, 1'b0);
    drive(0, 0, 0, 0, 24'h0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("to_idle_sel", c, 24'(bus.selection), (c < 10) ? 24'd1 : 24'd0);
    end

    // A tick restarts the count: timeout lands 10 cycles after the inc.
    drive(1, 0, 0, 0, 24'h0);
    step();
    drive(0, 0, 0, 0, 24'h0);
    for (int c = 1; c <= 4; c++) step();
    drive(0, 1, 0, 0, 24'h0);
    step();
    chk_all("to_inc", 0, 2'd1, 24'h071501, 1'b0);
    drive(0, 0, 0, 0, 24'h0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("to_restart_sel", c, 24'(bus.selection), (c < 10) ? 24'd1 : 24'd0);
    end

    // Reset in the middle of a minutes edit discards everything.
    drive(1, 0, 0, 0, 24'h0);
    step();
    step();
    drive(0, 0, 0, 0, 24'h0);
    for (int c = 1; c <= 3; c++) step();
    drive(0, 1, 0, 0, 24'h0);
    step();
    chk_all("mid_edit", 0, 2'd2, 24'h071601, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 24'h0);
    chk_all("mid_reset", 0, 2'd0, 24'h000000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
